// File: rtl/fpu_mul_arbiter.sv
// Two-port round-robin front end for a shared radix-4 Booth multiplier.
// Operands registered in S1, products in S2: fixed 2-cycle latency.
module multiply_32bit (
   input  logic [31:0] i_ad,
   input  logic [31:0] i_bd,
   input  logic        i_as,
   input  logic        i_bs,
   output logic [63:0] o_p
);
   logic [63:0] w_ma;
   logic [34:0] w_mb;
   logic [63:0] w_pp;
   logic [2:0]  w_trip;

   // i_bs extends the multiplicand (AD), i_as extends the multiplier (BD)
   always_comb begin
      w_ma   = {{32{i_bs & i_ad[31]}}, i_ad};
      w_mb   = {{2{i_as & i_bd[31]}}, i_bd, 1'b0};
      w_pp   = '0;
      w_trip = '0;
      o_p    = '0;
      for (int i = 0; i < 17; i++) begin
         w_trip = w_mb[2*i +: 3];
         case (w_trip)
            3'b001, 3'b010: w_pp = w_ma;
            3'b011:         w_pp = w_ma << 1;
            3'b100:         w_pp = ~(w_ma << 1) + 64'd1;
            3'b101, 3'b110: w_pp = ~w_ma + 64'd1;
            default:        w_pp = '0;
         endcase
         o_p = o_p + (w_pp << (2*i));
      end
   end
endmodule

module fpu_mul_arbiter #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic [1:0]       req0_op,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   input  logic [1:0]       req1_op,
   input  logic [TAG_W-1:0] req1_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [63:0]      rsp_full,
   output logic [31:0]      rsp_data,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);
   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULH   = 2'b01;
   localparam logic [1:0] OP_MULHSU = 2'b10;

   logic             r_s1_v;
   logic [31:0]      r_s1_a;
   logic [31:0]      r_s1_b;
   logic [1:0]       r_s1_op;
   logic [TAG_W-1:0] r_s1_tag;
   logic             r_s1_id;
   logic             r_s2_v;
   logic [1:0]       r_s2_op;
   logic [TAG_W-1:0] r_s2_tag;
   logic             r_s2_id;
   logic [63:0]      r_s2_full;
   logic             r_rr;
   logic [CNT_W-1:0] r_done_cnt;

   logic        w_adv2;
   logic        w_can_acc;
   logic        w_gnt0;
   logic        w_gnt1;
   logic        w_acc;
   logic        w_hs;
   logic        w_as;
   logic        w_bs;
   logic [63:0] w_prod;

   assign w_adv2    = ~r_s2_v | rsp_ready;
   assign w_can_acc = rst_n & ~flush & (~r_s1_v | w_adv2);
   assign w_gnt0    = req0_valid & (~req1_valid | ~r_rr);
   assign w_gnt1    = req1_valid & (~req0_valid | r_rr);
   assign req0_ready = w_can_acc & w_gnt0;
   assign req1_ready = w_can_acc & w_gnt1;
   assign w_acc     = req0_ready | req1_ready;
   assign w_hs      = r_s2_v & rsp_ready;
   assign w_bs      = (r_s1_op == OP_MULH) | (r_s1_op == OP_MULHSU);
   assign w_as      = (r_s1_op == OP_MULH);

   multiply_32bit u_mul (
      .i_ad (r_s1_a),
      .i_bd (r_s1_b),
      .i_as (w_as),
      .i_bs (w_bs),
      .o_p  (w_prod)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_v     <= 1'b0;
         r_s1_a     <= '0;
         r_s1_b     <= '0;
         r_s1_op    <= '0;
         r_s1_tag   <= '0;
         r_s1_id    <= 1'b0;
         r_s2_v     <= 1'b0;
         r_s2_op    <= '0;
         r_s2_tag   <= '0;
         r_s2_id    <= 1'b0;
         r_s2_full  <= '0;
         r_rr       <= 1'b0;
         r_done_cnt <= '0;
      end else begin
         if (w_hs)
            r_done_cnt <= r_done_cnt + CNT_W'(1);
         if (flush) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
         end else begin
            if (w_adv2) begin
               r_s2_v <= r_s1_v;
               if (r_s1_v) begin
                  r_s2_op   <= r_s1_op;
                  r_s2_tag  <= r_s1_tag;
                  r_s2_id   <= r_s1_id;
                  r_s2_full <= w_prod;
               end
            end
            // the winner's index is req1_ready; the other side gets priority next
            if (w_acc) begin
               r_s1_v   <= 1'b1;
               r_s1_a   <= req1_ready ? req1_a   : req0_a;
               r_s1_b   <= req1_ready ? req1_b   : req0_b;
               r_s1_op  <= req1_ready ? req1_op  : req0_op;
               r_s1_tag <= req1_ready ? req1_tag : req0_tag;
               r_s1_id  <= req1_ready;
               r_rr     <= ~req1_ready;
            end else if (w_adv2) begin
               r_s1_v <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid = r_s2_v;
   assign rsp_id    = r_s2_id;
   assign rsp_tag   = r_s2_tag;
   assign rsp_full  = r_s2_full;
   assign rsp_data  = (r_s2_op == OP_MUL) ? r_s2_full[31:0] : r_s2_full[63:32];
   assign busy      = r_s1_v | r_s2_v;
   assign done_cnt  = r_done_cnt;

   // requesters keep valid and payload steady until accepted, except across a flush
   a_req0_hold: assert property (@(posedge clk) disable iff (!rst_n)
      req0_valid && !req0_ready && !flush |=>
      req0_valid && $stable({req0_a, req0_b, req0_op, req0_tag}));
   a_req1_hold: assert property (@(posedge clk) disable iff (!rst_n)
      req1_valid && !req1_ready && !flush |=>
      req1_valid && $stable({req1_a, req1_b, req1_op, req1_tag}));
endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Bench for fpu_mul_arbiter: response scoreboard plus directed scenarios
// for latency, signedness, contention, backpressure, flush and reset.
`timescale 1ns/1ps
module tb_fpu_mul_arbiter;
   localparam int TAG_W = 4;
   localparam int CNT_W = 16;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             req0_valid;
   logic             req0_ready;
   logic [31:0]      req0_a;
   logic [31:0]      req0_b;
   logic [1:0]       req0_op;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid;
   logic             req1_ready;
   logic [31:0]      req1_a;
   logic [31:0]      req1_b;
   logic [1:0]       req1_op;
   logic [TAG_W-1:0] req1_tag;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [TAG_W-1:0] rsp_tag;
   logic [63:0]      rsp_full;
   logic [31:0]      rsp_data;
   logic             busy;
   logic [CNT_W-1:0] done_cnt;

   typedef struct packed {
      logic             id;
      logic [TAG_W-1:0] tag;
      logic [63:0]      full;
      logic [31:0]      data;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk;
   int   n_fail;

   fpu_mul_arbiter #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req0_tag   (req0_tag),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .req1_tag   (req1_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_tag    (rsp_tag),
      .rsp_full   (rsp_full),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .done_cnt   (done_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t model(input logic id, input logic [31:0] a,
                                  input logic [31:0] b, input logic [1:0] op,
                                  input logic [TAG_W-1:0] tag);
      exp_t        r;
      logic [63:0] xa;
      logic [63:0] xb;
      logic [63:0] p;
      xa = {32'd0, a};
      xb = {32'd0, b};
      if (op == 2'b01 || op == 2'b10) xa = {{32{a[31]}}, a};
      if (op == 2'b01) xb = {{32{b[31]}}, b};
      p = xa * xb;
      r.id   = id;
      r.tag  = tag;
      r.full = p;
      r.data = (op == 2'b00) ? p[31:0] : p[63:32];
      return r;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            n_chk++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: got id=%0d tag=%0h full=%h, required no response",
                        rsp_id, rsp_tag, rsp_full);
            end else begin
               e = sb_q.pop_front();
               if ({rsp_id, rsp_tag, rsp_full, rsp_data} !== e) begin
                  n_fail++;
                  $display("FAIL sb_rsp: got id=%0d tag=%0h full=%h data=%h, required id=%0d tag=%0h full=%h data=%h",
                           rsp_id, rsp_tag, rsp_full, rsp_data, e.id, e.tag, e.full, e.data);
               end
            end
         end
         if (flush) sb_q.delete();
         if (req0_valid && req0_ready)
            sb_q.push_back(model(1'b0, req0_a, req0_b, req0_op, req0_tag));
         if (req1_valid && req1_ready)
            sb_q.push_back(model(1'b1, req1_a, req1_b, req1_op, req1_tag));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [TAG_W-1:0] tag);
      if (p == 0) begin
         req0_a = a; req0_b = b; req0_op = op; req0_tag = tag; req0_valid = 1'b1;
      end else begin
         req1_a = a; req1_b = b; req1_op = op; req1_tag = tag; req1_valid = 1'b1;
      end
   endtask

   task automatic load(input int p);
      set_req(p, $urandom, $urandom, 2'($urandom_range(0, 3)), TAG_W'($urandom));
   endtask

   task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        output bit ok);
      int t;
      set_req(p, a, b, op, tag);
      ok = 1'b0;
      for (t = 0; t < 20; t++) begin
         @(negedge clk);
         if ((p == 0) ? req0_ready : req1_ready) begin
            ok = 1'b1;
            break;
         end
      end
      tick();
      if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
   endtask

   task automatic drain(output bit ok);
      logic g0;
      logic g1;
      ok = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         tick();
         if (g0) req0_valid = 1'b0;
         if (g1) req1_valid = 1'b0;
         if (!req0_valid && !req1_valid && !busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      n_chk++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got %b%b, required 00", req0_ready, req1_ready);
      end
      n_chk++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_valid_busy: got %b%b, required 00", rsp_valid, busy);
      end
      n_chk++;
      if (done_cnt !== '0 || rsp_full !== '0 || rsp_data !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got cnt=%0d full=%h data=%h, required zeros",
                  done_cnt, rsp_full, rsp_data);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      bit ok;
      int lat;
      issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 4'h5, ok);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL single_accept: got no ready, required ready within 20 cycles");
      end
      lat = 1;
      while (!rsp_valid && lat < 6) begin
         tick();
         lat++;
      end
      n_chk++;
      if (lat != 2) begin
         n_fail++;
         $display("FAIL single_latency: got %0d, required 2", lat);
      end
      n_chk++;
      if (rsp_full !== 64'hFFFF_FFFE_0000_0001 || rsp_data !== 32'hFFFF_FFFE) begin
         n_fail++;
         $display("FAIL single_product: got full=%h data=%h, required fffffffe00000001/fffffffe",
                  rsp_full, rsp_data);
      end
      n_chk++;
      if (rsp_id !== 1'b0 || rsp_tag !== 4'h5) begin
         n_fail++;
         $display("FAIL single_id_tag: got id=%0d tag=%0h, required 0/5", rsp_id, rsp_tag);
      end
      tick();
   endtask

   task automatic test_signed();
      logic [1:0]  ops [3] = '{2'b00, 2'b01, 2'b10};
      logic [63:0] ef  [3] = '{64'hFFFF_FFFE_0000_0001, 64'h1, 64'hFFFF_FFFF_0000_0001};
      logic [31:0] ed  [3] = '{32'h1, 32'h0, 32'hFFFF_FFFF};
      bit ok;
      int t;
      for (int k = 0; k < 3; k++) begin
         issue(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ops[k], TAG_W'(k + 8), ok);
         t = 0;
         while (!rsp_valid && t < 5) begin
            tick();
            t++;
         end
         n_chk++;
         if (!ok || rsp_valid !== 1'b1 || rsp_full !== ef[k] || rsp_data !== ed[k] || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL signed_op%0d: got v=%b full=%h data=%h id=%0d, required v=1 full=%h data=%h id=1",
                     ops[k], rsp_valid, rsp_full, rsp_data, rsp_id, ef[k], ed[k]);
         end
         tick();
      end
   endtask

   task automatic test_contention();
      int   gid[$];
      int   rid[$];
      int   first_g;
      int   first_r;
      int   last_r;
      int   n_both;
      int   bad;
      logic g0;
      logic g1;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      n_both = 0;
      first_g = -1;
      first_r = -1;
      last_r = -1;
      load(0);
      load(1);
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         if (g0 && g1) n_both++;
         if (g0 || g1) begin
            gid.push_back(int'(g1));
            if (first_g < 0) first_g = c;
         end
         if (rsp_valid) begin
            rid.push_back(int'(rsp_id));
            if (first_r < 0) first_r = c;
            last_r = c;
         end
         tick();
         if (g0) begin
            if (gid.size() >= 7) req0_valid = 1'b0; else load(0);
         end
         if (g1) begin
            if (gid.size() >= 7) req1_valid = 1'b0; else load(1);
         end
      end
      n_chk++;
      if (n_both != 0) begin
         n_fail++;
         $display("FAIL cont_dual_ready: got %0d cycles with both ready, required 0", n_both);
      end
      bad = 0;
      foreach (gid[i]) if (gid[i] != i % 2) bad++;
      n_chk++;
      if (gid.size() != 8 || bad != 0) begin
         n_fail++;
         $display("FAIL cont_grants: got %0d grants %0d out of order, required 8 alternating from 0",
                  gid.size(), bad);
      end
      bad = 0;
      foreach (rid[i]) if (rid[i] != i % 2) bad++;
      n_chk++;
      if (rid.size() != 8 || bad != 0 || last_r - first_r != 7 || first_r - first_g != 2) begin
         n_fail++;
         $display("FAIL cont_rsp: got n=%0d bad=%0d span=%0d lat=%0d, required 8 0 7 2",
                  rid.size(), bad, last_r - first_r, first_r - first_g);
      end
      n_chk++;
      if (done_cnt !== CNT_W'(8)) begin
         n_fail++;
         $display("FAIL cont_done_cnt: got %0d, required 8", done_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [CNT_W-1:0] base;
      logic [63:0]      h_full;
      logic [TAG_W-1:0] h_tag;
      logic             h_id;
      logic [31:0]      h_data;
      bit               have;
      int               unstable;
      int               acc;
      logic             g0;
      logic             g1;
      base = done_cnt;
      rsp_ready = 1'b0;
      have = 1'b0;
      unstable = 0;
      acc = 0;
      load(0);
      load(1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         if (g0 || g1) acc++;
         if (rsp_valid) begin
            if (!have) begin
               have = 1'b1;
               {h_id, h_tag, h_full, h_data} = {rsp_id, rsp_tag, rsp_full, rsp_data};
            end else if ({rsp_id, rsp_tag, rsp_full, rsp_data} !== {h_id, h_tag, h_full, h_data}) begin
               unstable++;
            end
         end
         tick();
         if (g0) begin
            if (acc == 1) load(0); else req0_valid = 1'b0;
         end
         if (g1) begin
            if (acc == 1) load(1); else req1_valid = 1'b0;
         end
      end
      n_chk++;
      if (acc != 2) begin
         n_fail++;
         $display("FAIL bp_accepts: got %0d, required 2", acc);
      end
      n_chk++;
      if (!have || unstable != 0) begin
         n_fail++;
         $display("FAIL bp_stable: got seen=%0d changes=%0d, required 1/0", have, unstable);
      end
      rsp_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         if (g0 || g1) acc++;
         tick();
         if (g0) req0_valid = 1'b0;
         if (g1) req1_valid = 1'b0;
         if (acc >= 3 && !busy) break;
      end
      n_chk++;
      if (acc != 3 || CNT_W'(done_cnt - base) !== CNT_W'(3) || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL bp_release: got acc=%0d done=%0d pending=%0d, required 3 3 0",
                  acc, CNT_W'(done_cnt - base), sb_q.size());
      end
   endtask

   task automatic test_flush();
      logic [CNT_W-1:0] base;
      logic             lastid;
      logic             g0;
      logic             g1;
      int               acc;
      bit               ok;
      rsp_ready = 1'b0;
      acc = 0;
      lastid = 1'b0;
      load(0);
      load(1);
      for (int c = 0; c < 4 && acc < 2; c++) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         if (g0 || g1) begin
            acc++;
            lastid = g1;
         end
         tick();
         if (g0) req0_valid = 1'b0;
         if (g1) req1_valid = 1'b0;
      end
      n_chk++;
      if (acc != 2 || busy !== 1'b1 || rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_fill: got acc=%0d busy=%b v=%b, required 2 1 1", acc, busy, rsp_valid);
      end
      base = done_cnt;
      flush = 1'b1;
      set_req(0, 32'h1234, 32'h5678, 2'b00, 4'hA);
      @(negedge clk);
      n_chk++;
      if (req0_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ready: got %b, required 0", req0_ready);
      end
      tick();
      flush = 1'b0;
      req0_valid = 1'b0;
      n_chk++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || done_cnt !== base) begin
         n_fail++;
         $display("FAIL flush_clear: got busy=%b v=%b cnt=%0d, required 0 0 %0d",
                  busy, rsp_valid, done_cnt, base);
      end
      rsp_ready = 1'b1;
      load(0);
      load(1);
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      n_chk++;
      if ({g1, g0} !== (lastid ? 2'b01 : 2'b10)) begin
         n_fail++;
         $display("FAIL flush_rr: got ready1/0=%b%b, required %b",
                  g1, g0, lastid ? 2'b01 : 2'b10);
      end
      tick();
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
      drain(ok);
      n_chk++;
      if (!ok || CNT_W'(done_cnt - base) !== CNT_W'(2)) begin
         n_fail++;
         $display("FAIL flush_after: got idle=%0d done=%0d, required 1 2",
                  ok, CNT_W'(done_cnt - base));
      end
   endtask

   task automatic test_async_reset();
      logic g0;
      logic g1;
      bit   ok;
      rsp_ready = 1'b1;
      load(0);
      load(1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         g0 = req0_ready;
         g1 = req1_ready;
         tick();
         if (g0) load(0);
         if (g1) load(1);
      end
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_pre: got busy=%b, required 1", busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || done_cnt !== '0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_full !== '0 || rsp_tag !== '0) begin
         n_fail++;
         $display("FAIL areset_now: got v=%b busy=%b cnt=%0d rdy=%b%b full=%h, required all zero",
                  rsp_valid, busy, done_cnt, req0_ready, req1_ready, rsp_full);
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      g0 = req0_ready;
      g1 = req1_ready;
      n_chk++;
      if (g0 !== 1'b1 || g1 !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_first_grant: got ready0/1=%b%b, required 10", g0, g1);
      end
      tick();
      if (g0) req0_valid = 1'b0;
      if (g1) req1_valid = 1'b0;
      drain(ok);
      n_chk++;
      if (!ok || done_cnt !== CNT_W'(2) || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL areset_after: got idle=%0d cnt=%0d pending=%0d, required 1 2 0",
                  ok, done_cnt, sb_q.size());
      end
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      rsp_ready = 1'b1;
      req0_valid = 1'b0;
      req0_a = '0;
      req0_b = '0;
      req0_op = '0;
      req0_tag = '0;
      req1_valid = 1'b0;
      req1_a = '0;
      req1_b = '0;
      req1_op = '0;
      req1_tag = '0;
      test_reset();
      test_single();
      test_signed();
      test_contention();
      test_backpressure();
      test_flush();
      test_async_reset();
      repeat (3) tick();
      n_chk++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_leftover: got %0d pending responses, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout at %0t, required end of test", $time);
      $fatal(1);
   end
endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
Two-requester round-robin arbiter and pipeline sequencer wrapped around one instance of the team's combinational 32x32 Booth multiplier (multiply_32bit). It gives the FPU mantissa path (req0) and the integer/aux path (req1) shared access to the multiplier through valid/ready handshakes. It registers operands (S1) and results (S2) for a fixed 2-cycle latency, and returns the 64-bit product with the requester ID and a tag.

Parameters:
TAG_W, 4, width of the opaque tag carried from request to response
CNT_W, 16, width of the completed-operation counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous flush; drops all in-flight operations
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  32  operand A
req0_b  in  32  operand B
req0_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
req0_tag  in  TAG_W  tag
req1_valid/req1_ready/req1_a/req1_b/req1_op/req1_tag  same as req0, for requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_id  out  1  requester index (0/1)
rsp_tag  out  TAG_W  tag echoed from request
rsp_full  out  64  full product
rsp_data  out  32  rsp_full[31:0] for MUL, rsp_full[63:32] otherwise
busy  out  1  S1 or S2 holds a valid operation
done_cnt  out  CNT_W  number of completed responses (rsp_valid & rsp_ready), wraps

Behaviour:
- Clock and reset: single clock clk. Asynchronous active-low reset rst_n. While rst_n=0: S1/S2 valid=0, rr pointer=0, done_cnt=0, all reqN_ready=0, rsp_valid=0, rsp_* data=0, busy=0.
- Multiplier hookup: AD=S1.a, BD=S1.b.
  - BS=1 when A is signed (MULH, MULHSU).
  - AS=1 when B is signed (MULH only).
  - MUL uses AS=BS=0; low 32 bits are sign-independent.
- Pipeline:
  - adv2 = ~S2.v | rsp_ready.
  - S1 advances into S2 when adv2. S2 loads {id, tag, op, product}; S2.v <= S1.v.
  - can_acc = ~S1.v | adv2.
- Arbitration (combinational, on reqN_valid and can_acc):
  - Only one valid requester: it wins.
  - Both valid: the requester at rr pointer wins.
  - reqN_ready = can_acc & grantN. At most one ready per cycle.
  - No ready asserts without a matching valid.
  - On accept, S1 captures {a, b, op, tag, id} and rr <= ~id. rr is unchanged otherwise.
- Latency: accept in cycle N -> rsp_valid in cycle N+2 when there is no backpressure. Sustained throughput is 1 op/cycle.
- Backpressure: while rsp_valid & ~rsp_ready, S2 holds all rsp_* outputs stable. S1 holds if valid. A new request is accepted only if S1 is empty.
- Simultaneous accept and advance: when S1 moves to S2 in the same cycle, S1 takes the new request. There are no bubbles.
- Flush:
  - In the flush cycle, S1.v and S2.v are cleared on the next edge.
  - reqN_ready is forced to 0 in the flush cycle.
  - rr and done_cnt are unchanged.
  - A response handshaked in the flush cycle still counts.
- done_cnt increments on rsp_valid & rsp_ready and wraps from 2^CNT_W-1 to 0.
- busy = S1.v | S2.v.
- Reset mid-operation: in-flight ops are lost and no response is emitted. Requesters must reissue.
- A requester must hold valid and payload stable until ready (checked by assertion). Deasserting valid before ready is legal only after flush.

Test Plan:
- Single op, req0 MULHU a=b=0xFFFFFFFF, rsp_ready=1 -> rsp_valid 2 cycles later: rsp_full=0xFFFFFFFE00000001, rsp_data=0xFFFFFFFE, rsp_id=0, tag echoed.
- Signedness sweep, a=b=0xFFFFFFFF:
  - MUL -> rsp_data=0x00000001.
  - MULH -> rsp_full=0x0000000000000001, rsp_data=0x00000000.
  - MULHSU -> rsp_full=0xFFFFFFFF00000001, rsp_data=0xFFFFFFFF.
- Contention: both requesters valid continuously for 8 cycles from reset -> grants alternate 0,1,0,1,…; 8 responses back-to-back with rsp_id alternating; done_cnt=8.
- Backpressure: rsp_ready=0 for 5 cycles with 3 pending requests -> exactly 2 accepted (S1, S2 full); rsp_* stable; no ready asserted; release -> remaining responses in order, no loss or duplication.
- Flush with S1 and S2 valid -> next cycle busy=0, rsp_valid=0, no response for flushed tags; done_cnt unchanged; rr preserved.
- Async reset asserted mid-stream (between clock edges) -> outputs zero immediately; after release first grant goes to req0 when both valid.
